// File: rtl/vrf_writeback_arbiter.sv
// Vector register file writeback arbiter: shares the single RF write port between
// the ALU and memory writeback paths. Optional statistics counters: VRF_WB_STATS_EN.
module vrf_writeback_arbiter #(
  parameter int unsigned THREADS      = 4,
  parameter int unsigned WORD_W       = 32,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                        clk,
  input  logic                        nRST,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [4:0]                  alu_wsel,
  input  logic [THREADS-1:0]          alu_wen,
  input  logic [THREADS*WORD_W-1:0]   alu_wdata,
  input  logic                        mem_valid,
  output logic                        mem_ready,
  input  logic [4:0]                  mem_wsel,
  input  logic [THREADS-1:0]          mem_wen,
  input  logic [THREADS*WORD_W-1:0]   mem_wdata,
  output logic [4:0]                  rf_wsel,
  output logic [THREADS-1:0]          rf_wen,
  output logic [THREADS*WORD_W-1:0]   rf_wdata,
  output logic                        last_grant_mem
`ifdef VRF_WB_STATS_EN
  ,
  output logic [15:0]                 conflict_cnt,
  output logic [15:0]                 forced_cnt,
  output logic [15:0]                 null_cnt
`endif
);

  localparam int unsigned DATA_W = THREADS * WORD_W;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic                 w_alu_real, w_alu_null, w_mem_real, w_mem_null;
  logic                 w_both_real, w_alu_starved;
  logic                 w_alu_grant, w_mem_grant;
  logic [CNT_W-1:0]     r_starve_cnt;
  logic [4:0]           r_wsel;
  logic [THREADS-1:0]   r_wen;
  logic [DATA_W-1:0]    r_wdata;
  logic                 r_last_mem;

  // Request classification: null writes are acknowledged without using the port
  always_comb begin
    w_alu_real    = alu_valid && (alu_wsel != 5'd0) && (alu_wen != '0);
    w_alu_null    = alu_valid && !w_alu_real;
    w_mem_real    = mem_valid && (mem_wsel != 5'd0) && (mem_wen != '0);
    w_mem_null    = mem_valid && !w_mem_real;
    w_both_real   = w_alu_real && w_mem_real;
    w_alu_starved = (r_starve_cnt == LIMIT);
    w_mem_grant   = w_mem_real && !(w_alu_real && w_alu_starved);
    w_alu_grant   = w_alu_real && !w_mem_grant;
    alu_ready     = w_alu_grant || w_alu_null;
    mem_ready     = w_mem_grant || w_mem_null;
  end

  // Starvation counter: counts consecutive real ALU losses, saturating at the limit
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_starve_cnt <= '0;
    end else if (w_alu_grant) begin
      r_starve_cnt <= '0;
    end else if (w_alu_real && (r_starve_cnt < LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  // Registered write stage; only the enable drops when nothing is granted
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_wsel     <= '0;
      r_wen      <= '0;
      r_wdata    <= '0;
      r_last_mem <= 1'b0;
    end else if (w_mem_grant) begin
      r_wsel     <= mem_wsel;
      r_wen      <= mem_wen;
      r_wdata    <= mem_wdata;
      r_last_mem <= 1'b1;
    end else if (w_alu_grant) begin
      r_wsel     <= alu_wsel;
      r_wen      <= alu_wen;
      r_wdata    <= alu_wdata;
      r_last_mem <= 1'b0;
    end else begin
      r_wen      <= '0;
    end
  end

  assign rf_wsel        = r_wsel;
  assign rf_wen         = r_wen;
  assign rf_wdata       = r_wdata;
  assign last_grant_mem = r_last_mem;

`ifdef VRF_WB_STATS_EN
  logic [15:0] r_conflict_cnt, r_forced_cnt, r_null_cnt;
  logic [16:0] w_null_sum;

  always_comb begin
    w_null_sum = 17'(r_null_cnt) + 17'(w_alu_null) + 17'(w_mem_null);
  end

  // Saturating statistics counters
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_conflict_cnt <= '0;
      r_forced_cnt   <= '0;
      r_null_cnt     <= '0;
    end else begin
      if (w_both_real && (r_conflict_cnt != 16'hFFFF))
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
      if (w_both_real && w_alu_grant && (r_forced_cnt != 16'hFFFF))
        r_forced_cnt <= r_forced_cnt + 16'd1;
      r_null_cnt <= (w_null_sum > 17'h0FFFF) ? 16'hFFFF : w_null_sum[15:0];
    end
  end

  assign conflict_cnt = r_conflict_cnt;
  assign forced_cnt   = r_forced_cnt;
  assign null_cnt     = r_null_cnt;
`endif

endmodule

// File: tb/tb_vrf_writeback_arbiter.sv
// Self-checking bench for vrf_writeback_arbiter: vector table plus directed
// sequences for reset, starvation, and same-register collision.
module tb_vrf_writeback_arbiter;

  localparam int unsigned THREADS = 4;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned DW      = THREADS * WORD_W;

  logic            clk = 1'b0;
  logic            nRST;
  logic            alu_valid, mem_valid;
  logic            alu_ready, mem_ready;
  logic [4:0]      alu_wsel, mem_wsel, rf_wsel;
  logic [3:0]      alu_wen, mem_wen, rf_wen;
  logic [DW-1:0]   alu_wdata, mem_wdata, rf_wdata;
  logic            last_grant_mem;
`ifdef VRF_WB_STATS_EN
  logic [15:0]     conflict_cnt, forced_cnt, null_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [DW-1:0] A_DATA = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
  localparam logic [DW-1:0] M_DATA = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

  always #5 clk = ~clk;

  vrf_writeback_arbiter #(.THREADS(THREADS), .WORD_W(WORD_W), .STARVE_LIMIT(3)) dut (
    .clk(clk), .nRST(nRST),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wsel(alu_wsel),
    .alu_wen(alu_wen), .alu_wdata(alu_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wsel(mem_wsel),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .rf_wsel(rf_wsel), .rf_wen(rf_wen), .rf_wdata(rf_wdata),
    .last_grant_mem(last_grant_mem)
`ifdef VRF_WB_STATS_EN
    , .conflict_cnt(conflict_cnt), .forced_cnt(forced_cnt), .null_cnt(null_cnt)
`endif
  );

  typedef struct {
    logic            av;
    logic [4:0]      aws;
    logic [3:0]      awen;
    logic [DW-1:0]   awd;
    logic            mv;
    logic [4:0]      mws;
    logic [3:0]      mwen;
    logic [DW-1:0]   mwd;
    logic            e_ar;
    logic            e_mr;
    logic [4:0]      e_wsel;
    logic [3:0]      e_wen;
    logic [DW-1:0]   e_wd;
    logic            e_lgm;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aws, input logic [3:0] awen,
                       input logic [DW-1:0] awd, input logic mv, input logic [4:0] mws,
                       input logic [3:0] mwen, input logic [DW-1:0] mwd);
    alu_valid = av; alu_wsel = aws; alu_wen = awen; alu_wdata = awd;
    mem_valid = mv; mem_wsel = mws; mem_wen = mwen; mem_wdata = mwd;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 4'd0, '0, 1'b0, 5'd0, 4'd0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    nRST = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nRST = 1'b1;
  endtask

  // Hold both requesters real for one cycle and check which side is granted
  task automatic both_cycle(input string tag, input logic exp_mem);
    @(negedge clk);
    drive(1'b1, 5'd12, 4'b1111, A_DATA, 1'b1, 5'd13, 4'b1111, M_DATA);
    #1;
    check({tag, " mem_ready"}, DW'(mem_ready), DW'(exp_mem));
    check({tag, " alu_ready"}, DW'(alu_ready), DW'(!exp_mem));
    @(posedge clk);
    #1;
    check({tag, " rf_wsel"}, DW'(rf_wsel), exp_mem ? DW'(5'd13) : DW'(5'd12));
    check({tag, " last_grant_mem"}, DW'(last_grant_mem), DW'(exp_mem));
  endtask

  initial begin
    logic [7:0] grant_seq;
    bit         alu_done;
    int         cyc;

    nRST = 1'b0;
    idle();

    //                av    aws    awen     awd     mv    mws    mwen     mwd     ar    mr    wsel   wen      wd      lgm
    vecs[0] = '{1'b0, 5'd0,  4'b0000, '0,     1'b0, 5'd0,  4'b0000, '0,     1'b0, 1'b0, 5'd0,  4'b0000, '0,     1'b0};
    vecs[1] = '{1'b1, 5'd5,  4'b1010, A_DATA, 1'b0, 5'd0,  4'b0000, '0,     1'b1, 1'b0, 5'd5,  4'b1010, A_DATA, 1'b0};
    vecs[2] = '{1'b0, 5'd0,  4'b0000, '0,     1'b0, 5'd0,  4'b0000, '0,     1'b0, 1'b0, 5'd5,  4'b0000, A_DATA, 1'b0};
    vecs[3] = '{1'b0, 5'd0,  4'b0000, '0,     1'b1, 5'd9,  4'b1111, M_DATA, 1'b0, 1'b1, 5'd9,  4'b1111, M_DATA, 1'b1};
    vecs[4] = '{1'b1, 5'd0,  4'b1111, A_DATA, 1'b1, 5'd3,  4'b0011, M_DATA, 1'b1, 1'b1, 5'd3,  4'b0011, M_DATA, 1'b1};
    vecs[5] = '{1'b0, 5'd0,  4'b0000, '0,     1'b1, 5'd4,  4'b0000, A_DATA, 1'b0, 1'b1, 5'd3,  4'b0000, M_DATA, 1'b1};
    vecs[6] = '{1'b1, 5'd6,  4'b0000, A_DATA, 1'b1, 5'd0,  4'b1111, A_DATA, 1'b1, 1'b1, 5'd3,  4'b0000, M_DATA, 1'b1};
    vecs[7] = '{1'b0, 5'd8,  4'b1111, A_DATA, 1'b0, 5'd9,  4'b1111, A_DATA, 1'b0, 1'b0, 5'd3,  4'b0000, M_DATA, 1'b1};

    // Reset state
    #12;
    check("reset rf_wsel", DW'(rf_wsel), '0);
    check("reset rf_wen", DW'(rf_wen), '0);
    check("reset rf_wdata", rf_wdata, '0);
    check("reset last_grant_mem", DW'(last_grant_mem), '0);
    @(negedge clk);
    nRST = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vecs[i].av, vecs[i].aws, vecs[i].awen, vecs[i].awd,
            vecs[i].mv, vecs[i].mws, vecs[i].mwen, vecs[i].mwd);
      #1;
      check($sformatf("vec%0d alu_ready", i), DW'(alu_ready), DW'(vecs[i].e_ar));
      check($sformatf("vec%0d mem_ready", i), DW'(mem_ready), DW'(vecs[i].e_mr));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d rf_wsel", i), DW'(rf_wsel), DW'(vecs[i].e_wsel));
      check($sformatf("vec%0d rf_wen", i), DW'(rf_wen), DW'(vecs[i].e_wen));
      check($sformatf("vec%0d rf_wdata", i), rf_wdata, vecs[i].e_wd);
      check($sformatf("vec%0d last_grant_mem", i), DW'(last_grant_mem), DW'(vecs[i].e_lgm));
    end

    // Starvation: M,M,M,A,M,M,M,A (1 = memory grant)
    grant_seq = 8'b1110_1110;
    for (int i = 0; i < 8; i++)
      both_cycle($sformatf("starve%0d", i), grant_seq[7-i]);

    // Same-register collision: memory first, ALU once starvation limit is hit
    alu_done = 1'b0;
    cyc = 0;
    while (!alu_done && cyc < 10) begin
      @(negedge clk);
      drive(1'b1, 5'd7, 4'b1111, A_DATA, 1'b1, 5'd7, 4'b1111, M_DATA);
      #1;
      alu_done = alu_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (!alu_done)
        check($sformatf("collide%0d rf_wdata mem", cyc), rf_wdata, M_DATA);
    end
    check("collide alu grant cycle", DW'(cyc), DW'(4));
    check("collide final rf_wsel", DW'(rf_wsel), DW'(5'd7));
    check("collide final rf_wdata", rf_wdata, A_DATA);
    check("collide final last_grant_mem", DW'(last_grant_mem), '0);

    // Asynchronous reset in the middle of a grant
    @(negedge clk);
    drive(1'b0, 5'd0, 4'd0, '0, 1'b1, 5'd21, 4'b0110, M_DATA);
    @(posedge clk);
    #1;
    check("pre-reset rf_wen", DW'(rf_wen), DW'(4'b0110));
    #2;
    nRST = 1'b0;
    #1;
    check("async reset rf_wsel", DW'(rf_wsel), '0);
    check("async reset rf_wen", DW'(rf_wen), '0);
    check("async reset rf_wdata", rf_wdata, '0);
    check("async reset last_grant_mem", DW'(last_grant_mem), '0);
    @(negedge clk);
    idle();
    @(negedge clk);
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post-reset idle%0d rf_wen", i), DW'(rf_wen), '0);
    end

`ifdef VRF_WB_STATS_EN
    do_reset();
    for (int i = 0; i < 10; i++)
      both_cycle($sformatf("stats%0d", i), (i % 4) != 3);
    @(negedge clk);
    idle();
    check("conflict_cnt", DW'(conflict_cnt), DW'(16'd10));
    check("forced_cnt", DW'(forced_cnt), DW'(16'd2));
    check("null_cnt", DW'(null_cnt), DW'(16'd0));
    drive(1'b1, 5'd0, 4'b1111, A_DATA, 1'b1, 5'd2, 4'b0000, M_DATA);
    @(posedge clk);
    #1;
    check("null_cnt two nulls", DW'(null_cnt), DW'(16'd2));
`else
    do_reset();
`endif

    @(negedge clk);
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/vrf_writeback_arbiter.md
Name: vrf_writeback_arbiter

Overview:
- Shares the single write port of the vector register file (32 x THREADS words, per-thread write-enable mask) between two writeback requesters: the ALU pipeline and the load/memory unit.
- Performs valid/ready arbitration with memory priority and a starvation guard for the ALU.
- Drops null writes (register 0, or an all-zero thread mask) without consuming the port.
- Presents one registered write per cycle to the register file.

Parameters:
- THREADS, 4, number of SIMT lanes (width of each write-enable mask).
- WORD_W, 32, lane data width in bits.
- STARVE_LIMIT, 3, number of consecutive lost ALU arbitration cycles before the ALU is forced to win. Legal range 1..15.

Ports:
- clk  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_wsel  in  5  ALU destination register
- alu_wen  in  THREADS  ALU per-lane write mask
- alu_wdata  in  THREADS*WORD_W  ALU lane data; lane i in bits [i*WORD_W +: WORD_W]
- mem_valid  in  1  memory writeback request
- mem_ready  out  1  memory request accepted this cycle
- mem_wsel  in  5  memory destination register
- mem_wen  in  THREADS  memory per-lane write mask
- mem_wdata  in  THREADS*WORD_W  memory lane data
- rf_wsel  out  5  register file write select
- rf_wen  out  THREADS  register file per-lane write enable
- rf_wdata  out  THREADS*WORD_W  register file write data
- last_grant_mem  out  1  1 when the last real write came from memory

Behaviour:
- Reset:
  - rf_wsel=0, rf_wen=0, rf_wdata=0, last_grant_mem=0.
  - Starvation counter cleared.
  - Reset is asynchronous: any in-flight registered write is discarded.
- Null request: valid && (wsel==0 || wen==0).
  - Its ready is asserted combinationally in the same cycle, regardless of the other requester.
  - It never reaches the rf_* outputs.
  - It does not affect the starvation counter.
- Real request: valid && wsel!=0 && wen!=0. At most one real request is granted per cycle.
- Arbitration when both requests are real:
  - Memory wins by default.
  - ALU wins when starve_cnt == STARVE_LIMIT.
- Arbitration when only one request is real: that requester wins.
- Ready outputs:
  - ready = grant for real requests, or 1 for null requests.
  - Ready outputs are combinational from the valid, wsel, wen inputs and starve_cnt only; never from ready inputs (there are none).
- Starvation counter (4-bit):
  - Increments when the ALU is real and loses.
  - Clears when the ALU is granted.
  - Holds otherwise.
  - Saturates at STARVE_LIMIT.
- Output stage:
  - On the clock edge after a grant, rf_wsel/rf_wen/rf_wdata take the winner's fields.
  - last_grant_mem updates to the winner's source.
  - With no grant, rf_wen returns to 0. rf_wsel, rf_wdata and last_grant_mem hold.
  - Latency is exactly 1 cycle from acceptance to the rf_* outputs. The register file commits on the following edge.
- The register file port always accepts, so there is no backpressure from it.
- Same destination register on both requesters: the writes are committed in grant order; the later grant overwrites per lane. No merging is performed.
- Requesters must hold valid and fields stable until ready; the arbiter does not check this.

Optional Feature:
- Macro: VRF_WB_STATS_EN.
- When defined, the block adds the following outputs:
  - conflict_cnt (16 bits): counts cycles in which both requests are real.
  - forced_cnt (16 bits): counts ALU grants caused by the starvation limit.
  - null_cnt (16 bits): counts accepted null requests, up to 2 per cycle.
- All three counters saturate at 16'hFFFF and reset to 0.
- When not defined, these ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Reset: assert nRST=0 mid-grant -> all rf_* outputs go to 0 immediately; after release with no requests, rf_wen stays 0.
- Single ALU request: wsel=5, wen=4'b1010, data lanes A/B/C/D -> alu_ready=1 the same cycle; next cycle rf_wsel=5, rf_wen=4'b1010, rf_wdata matches, last_grant_mem=0.
- Starvation with both requesters held valid and real, STARVE_LIMIT=3:
  - Grant sequence is M,M,M,A,M,M,M,A.
  - The ALU grant on every 4th cycle takes alu_wsel.
- Null writes:
  - alu_wsel=0 with mem real in the same cycle -> both readys=1; only the mem write appears on rf_*.
  - mem_wen=0 alone -> mem_ready=1 and rf_wen stays 0.
- Same register collision: both requesters target wsel=7 with full masks -> mem data committed first, ALU data one cycle later once starvation is reached; final rf_wdata is the ALU data.
- With VRF_WB_STATS_EN: 10 conflict cycles, STARVE_LIMIT=3 -> conflict_cnt=10 and forced_cnt=2.
